inst_rom_loader: RTL and testbench

Instruction-memory block that sits directly upstream of the CPU core's fetch port. It drives rom_data from rom_addr/rom_ce.
At boot it accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into an internal word array. The core is held in reset until the image is complete.
Replaces a static, pre-initialised instruction ROM, so test programs load at runtime.

---
 rtl/inst_rom_loader_pkg.sv | 26 ++
 rtl/inst_rom_loader_array.sv | 28 ++
 rtl/inst_rom_loader.sv | 147 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the runtime-loadable instruction ROM.
// Imported by the loader top and its word array.
package inst_rom_loader_pkg;

  localparam int BusWidth  = 32;
  localparam int ByteWidth = 8;
  localparam int LenWidth  = 16;

  localparam logic [BusWidth-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    RUN    = 3'd3,
    ERR    = 3'd4
  } state_e;

  function automatic logic [BusWidth-1:0] pack_word(
    input logic [23:0]          hi,
    input logic [ByteWidth-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/inst_rom_loader_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so images survive a loader reset.
module inst_rom_array
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [BusWidth-1:0]   rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BusWidth-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader + instruction ROM: assembles a length-prefixed big-endian
// byte stream into words and holds the core in reset until it is complete.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = LenWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_data_i,
  output logic                  ld_ready_o,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  output logic                  cpu_rst_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic [ADDR_WIDTH:0]   word_cnt_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [LEN_WIDTH:0] DepthL =
    (LEN_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PtrOne =
    (ADDR_WIDTH+1)'(1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0]              idx_q, idx_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [23:0]             sh_q, sh_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic [LEN_WIDTH-1:0]    len_w;
  logic [ADDR_WIDTH:0]     wr_ptr_inc;
  logic                    we;
  logic [BusWidth-1:0]     wdata;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [BusWidth-1:0]     rdata;
  logic                    unused_addr;

  assign ld_ready_o = (state_q == LEN_HI) ||
                      (state_q == LEN_LO) ||
                      (state_q == DATA);

  assign accept     = ld_valid_i & ld_ready_o;
  assign len_w      = LEN_WIDTH'({len_q[15:8], ld_data_i});
  assign wr_ptr_inc = wr_ptr_q + PtrOne;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    len_d    = len_q;
    sh_d     = sh_q;
    we       = 1'b0;
    waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
    wdata    = pack_word(sh_q, ld_data_i);
    if (accept) begin
      unique case (1'b1)
        (state_q == LEN_HI): begin
          len_d[15:8] = ld_data_i;
          state_d     = LEN_LO;
        end
        (state_q == LEN_LO): begin
          len_d = len_w;
          if ({1'b0, len_w} > DepthL) begin
            state_d = ERR;
          end else if (len_w == '0) begin
            state_d = RUN;
          end else begin
            state_d = DATA;
          end
        end
        (state_q == DATA): begin
          idx_d = idx_q + 2'd1;
          sh_d  = {sh_q[15:0], ld_data_i};
          // 4th byte completes the word and commits it this edge
          if (idx_q == 2'd3) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_inc;
            if (wr_ptr_inc == len_q[ADDR_WIDTH:0]) begin
              state_d = RUN;
            end
          end
        end
        default: begin
        end
      endcase
    end
    cpu_rst_d = (state_d != RUN);
    done_d    = (state_d == RUN);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LEN_HI;
      wr_ptr_q  <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      sh_q      <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      sh_q      <= sh_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign raddr = rom_addr_i[ADDR_WIDTH+1:2];

  // Upper address bits alias; byte offset is irrelevant for word fetch
  assign unused_addr = ^{rom_addr_i[31:ADDR_WIDTH+2],
                         rom_addr_i[1:0]};

  inst_rom_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign rom_data_o  = (rom_ce_i && !cpu_rst_q) ? rdata : ZeroWord;
  assign cpu_rst_o   = cpu_rst_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  assign word_cnt_o  = wr_ptr_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_inst_rom_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  typedef logic [7:0] bytes_t [$];

  localparam int K_DATA = 0;
  localparam int K_CNT  = 1;
  localparam int K_DONE = 2;
  localparam int K_RST  = 3;
  localparam int K_ERR  = 4;
  localparam int K_RDY  = 5;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid_i;
  logic [7:0]    ld_data_i;
  logic          ld_ready_o;
  logic          rom_ce_i;
  logic [31:0]   rom_addr_i;
  logic [31:0]   rom_data_o;
  logic          cpu_rst_o;
  logic          load_done_o;
  logic          load_err_o;
  logic [AW:0]   word_cnt_o;

  exp_t          sb [$];
  int            tests = 0;
  int            fails = 0;

  logic [31:0]   exp_mem [DEPTH];
  int            m_cnt;
  bit            m_done;
  bit            m_err;

  always #5 clk = ~clk;

  inst_rom_loader #(
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .rom_ce_i    (rom_ce_i),
    .rom_addr_i  (rom_addr_i),
    .rom_data_o  (rom_data_o),
    .cpu_rst_o   (cpu_rst_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o),
    .word_cnt_o  (word_cnt_o)
  );

  function automatic string kname(input int k);
    case (k)
      K_DATA:  return "rom_data";
      K_CNT:   return "word_cnt";
      K_DONE:  return "load_done";
      K_RST:   return "cpu_rst";
      K_ERR:   return "load_err";
      default: return "ld_ready";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_DATA:  a = rom_data_o;
        K_CNT:   a = 32'(word_cnt_o);
        K_DONE:  a = 32'(load_done_o);
        K_RST:   a = 32'(cpu_rst_o);
        K_ERR:   a = 32'(load_err_o);
        default: a = 32'(ld_ready_o);
      endcase
      tests++;
      if (a !== e.val) begin
        fails++;
        $display("FAIL %s: got %h expected %h @%0t",
                 kname(e.kind), a, e.val, $time);
      end
    end
  end

  function automatic void model_load(input bytes_t s);
    int n, len, w;
    n = s.size();
    m_cnt = 0; m_done = 0; m_err = 0;
    if (n >= 2) begin
      len = int'({s[0], s[1]});
      if (len > DEPTH) begin
        m_err = 1;
      end else begin
        w = (n - 2) / 4;
        if (w > len) w = len;
        for (int j = 0; j < w; j++)
          exp_mem[j] = {s[2+4*j], s[3+4*j], s[4+4*j], s[5+4*j]};
        m_cnt  = w;
        m_done = (w == len);
      end
    end
  endfunction

  function automatic bytes_t prefix(input bytes_t s, input int n);
    bytes_t r;
    for (int i = 0; i < n; i++) r.push_back(s[i]);
    return r;
  endfunction

  task automatic push(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status();
    push(K_CNT,  32'(m_cnt));
    push(K_DONE, 32'(m_done));
    push(K_RST,  32'(!m_done));
    push(K_ERR,  32'(m_err));
    push(K_RDY,  32'(!(m_done || m_err)));
    tick();
  endtask

  task automatic do_reset(input logic v, input logic [7:0] d);
    rst        = 1'b1;
    ld_valid_i = v;
    ld_data_i  = d;
    tick();
    tick();
    rst        = 1'b0;
    ld_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok         = 0;
    ld_valid_i = 1'b1;
    ld_data_i  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = ld_ready_o;
      tick();
    end
    ld_valid_i = 1'b0;
    tests++;
    if (ok !== 1'b1) begin
      fails++;
      $display("FAIL ready wait expired for byte %h @%0t",
               b, $time);
    end
  endtask

  task automatic send_range(input bytes_t s, input int from,
                            input int to, input int maxidle);
    for (int i = from; i < to; i++) begin
      repeat ($urandom_range(0, maxidle)) tick();
      send_byte(s[i]);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] v);
    rom_ce_i   = 1'b1;
    rom_addr_i = addr;
    push(K_DATA, v);
    tick();
  endtask

  task automatic rd_all(input int n);
    logic [31:0] a;
    for (int j = 0; j < n; j++) begin
      a = ($urandom() & 32'hFFFF_F003) | (32'(j) << 2);
      rd(a, exp_mem[j]);
    end
  endtask

  initial begin
    bytes_t s1, s, h;
    int     len, idx;

    rst        = 1'b1;
    ld_valid_i = 1'b0;
    ld_data_i  = '0;
    rom_ce_i   = 1'b0;
    rom_addr_i = '0;
    repeat (3) tick();
    rst = 1'b0;

    tests++;
    if ({ld_ready_o, cpu_rst_o, load_done_o, load_err_o} !== 4'b1100 ||
        word_cnt_o !== '0 || rom_data_o !== 32'h0) begin
      fails++;
      $display("FAIL reset state: rdy=%b rst=%b done=%b err=%b cnt=%0d",
               ld_ready_o, cpu_rst_o, load_done_o, load_err_o,
               word_cnt_o);
    end

    model_load(h);
    check_status();
    rd(32'h0, 32'h0);

    s1 = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00,
           8'h34, 8'h02, 8'h00, 8'h20};
    send_range(s1, 0, 9, 0);
    model_load(prefix(s1, 9));
    check_status();
    send_range(s1, 9, 10, 0);
    model_load(s1);
    check_status();
    rd(32'h0, 32'h3401_1100);
    rd(32'h4, 32'h3402_0020);

    rom_ce_i = 1'b0;
    push(K_DATA, 32'h0);
    tick();
    rd(32'h1000, 32'h3401_1100);
    rd(32'h7, 32'h3402_0020);

    do_reset(1'b0, 8'h00);
    send_range(s1, 0, 10, 3);
    model_load(s1);
    check_status();
    for (int i = 0; i < 6; i++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = 8'($urandom());
      push(K_RDY, 32'd0);
      push(K_CNT, 32'd2);
      tick();
    end
    ld_valid_i = 1'b0;
    rd_all(2);

    do_reset(1'b0, 8'h00);
    s = '{8'h00, 8'h00};
    send_range(s, 0, 1, 0);
    model_load(prefix(s, 1));
    check_status();
    send_range(s, 1, 2, 0);
    model_load(s);
    check_status();

    do_reset(1'b0, 8'h00);
    s = '{8'h04, 8'h01};
    send_range(s, 0, 2, 0);
    model_load(s);
    check_status();
    ld_valid_i = 1'b1;
    repeat (4) tick();
    ld_valid_i = 1'b0;
    check_status();
    rd(32'h0, 32'h0);
    do_reset(1'b0, 8'h00);
    model_load(h);
    check_status();

    send_range(s1, 0, 7, 0);
    model_load(prefix(s1, 7));
    check_status();
    do_reset(1'b1, 8'hFF);
    model_load(h);
    check_status();
    send_range(s1, 0, 10, 1);
    model_load(s1);
    check_status();
    rd_all(2);

    for (int t = 0; t < 6; t++) begin
      do_reset(1'b0, 8'h00);
      len = $urandom_range(1, 12);
      s.delete();
      s.push_back(8'(len >> 8));
      s.push_back(8'(len));
      for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom()));
      send_range(s, 0, s.size() - 1, 2);
      model_load(prefix(s, s.size() - 1));
      check_status();
      send_range(s, s.size() - 1, s.size(), 0);
      model_load(s);
      check_status();
      rd_all(len);
    end

    do_reset(1'b0, 8'h00);
    s.delete();
    s.push_back(8'h04);
    s.push_back(8'h00);
    for (int i = 0; i < 4 * DEPTH; i++) s.push_back(8'($urandom()));
    send_range(s, 0, s.size(), 0);
    model_load(s);
    check_status();
    rd(32'(DEPTH - 1) << 2, exp_mem[DEPTH-1]);
    rd(32'h0, exp_mem[0]);
    for (int i = 0; i < 5; i++) begin
      idx = $urandom_range(0, DEPTH - 1);
      rd(32'(idx) << 2, exp_mem[idx]);
    end

    rom_ce_i = 1'b0;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
